regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
- CNT_W, default 16, width of the committed-write counter.
- FIRST_PORT, default 0, port favoured on the first grant after reset.

REQ-002 Ports SHALL be:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- HOLD  in  1  core stall; while 1, no grant is issued.
- P0_VALID  in  1  ALU writeback request.
- P0_ADDR  in  5  ALU destination register.
- P0_DATA  in  32  ALU result.
- P0_READY  out  1  ALU request accepted this cycle.
- P1_VALID  in  1  load writeback request.
- P1_ADDR  in  5  load destination register.
- P1_DATA  in  32  load data.
- P1_READY  out  1  load request accepted this cycle.
- A3  out  5  register-file write address.
- WD3  out  32  register-file write data.
- RegWrite  out  1  register-file write enable.
- WR_COUNT  out  CNT_W  number of writes committed to the register file.

REQ-003 The clock SHALL be CLK, and reset SHALL be RESET: one clock domain, asynchronous, active-high.

Function
REQ-004 The block SHALL share the single register-file write port between two requesters using a valid/ready handshake; a transfer occurs on a rising edge where Pn_VALID=1 and Pn_READY=1.

REQ-005 Pn_READY SHALL be combinational from the VALID inputs, HOLD and the priority pointer; at most one READY SHALL be 1 per cycle.

REQ-006 When HOLD=1, both READY outputs SHALL be 0.

REQ-007 Arbitration SHALL use a 1-bit priority pointer PRI (the port favoured next):
- Only one port valid: that port is granted.
- Both ports valid: port PRI is granted.

REQ-008 After each transfer, PRI SHALL be set to the non-granted port; with no transfer, PRI SHALL hold.

REQ-009 A3, WD3 and RegWrite SHALL be registered; a transfer at edge N SHALL drive A3/WD3 with the granted ADDR/DATA, and RegWrite=1, during cycle N+1 (latency 1).

REQ-010 A transfer with ADDR=0 SHALL be accepted (READY=1) but SHALL NOT assert RegWrite, SHALL NOT change A3/WD3, and SHALL NOT increment WR_COUNT.

REQ-011 With no transfer at an edge, RegWrite SHALL be 0 in the following cycle, and A3/WD3 SHALL hold their last values.

REQ-012 WR_COUNT SHALL increment by 1 for every cycle in which RegWrite=1, wrapping from 2^CNT_W-1 to 0.

REQ-013 Two requests to the same address in consecutive transfers SHALL produce two register-file writes in grant order, with no merging.

REQ-014 A requester holding VALID without READY SHALL be served within 2 cycles once HOLD=0, which guarantees starvation freedom.

REQ-015 The block SHALL NOT buffer requests; Pn_ADDR/Pn_DATA are sampled only at the transfer edge.

Reset
REQ-016 While RESET=1, the following SHALL hold asynchronously:
- RegWrite=0, A3=0, WD3=0, WR_COUNT=0.
- PRI=FIRST_PORT.
- P0_READY=P1_READY=0.

REQ-017 RESET asserted mid-operation SHALL discard any write scheduled for the next cycle, so no RegWrite pulse follows reset release.

REQ-018 The first edge after RESET deasserts SHALL arbitrate normally.

Verification
REQ-019 Single port: P0_VALID=1, ADDR=5, DATA=0xDEADBEEF, HOLD=0 -> P0_READY=1 that cycle; next cycle RegWrite=1, A3=5, WD3=0xDEADBEEF; WR_COUNT=1.

REQ-020 Contention: both ports valid for 4 cycles (P0 ADDR=1, P1 ADDR=2), FIRST_PORT=0 -> grants P0,P1,P0,P1; A3 sequence 1,2,1,2 with one-cycle lag.

REQ-021 x0 drop: P1_VALID=1, ADDR=0, DATA=0x1234 -> P1_READY=1; next cycle RegWrite=0, A3/WD3 unchanged, WR_COUNT unchanged.

REQ-022 HOLD: both valid, HOLD=1 for 3 cycles -> both READY=0 and RegWrite=0 throughout; HOLD=0 -> grant goes to PRI.

REQ-023 Reset mid-operation: transfer at edge N, RESET asserted before edge N+1 -> RegWrite=0 immediately, WR_COUNT=0; after release no stale write appears.

REQ-024 Counter wrap: CNT_W=4, 17 non-zero-address writes -> WR_COUNT reads 0xF then 0x0 then 0x1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Round-robin priority, registered write outputs, writes to x0 are silently dropped.
module regfile_wb_arbiter #(
    parameter int   CNT_W      = 16,
    parameter logic FIRST_PORT = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             HOLD,
    input  logic             P0_VALID,
    input  logic [4:0]       P0_ADDR,
    input  logic [31:0]      P0_DATA,
    output logic             P0_READY,
    input  logic             P1_VALID,
    input  logic [4:0]       P1_ADDR,
    input  logic [31:0]      P1_DATA,
    output logic             P1_READY,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic             RegWrite,
    output logic [CNT_W-1:0] WR_COUNT
);

    logic             pri_r;
    logic             grant0_s;
    logic             grant1_s;
    logic [4:0]       sel_addr_s;
    logic [31:0]      sel_data_s;
    logic             commit_s;
    logic [4:0]       a3_r;
    logic [31:0]      wd3_r;
    logic             reg_write_r;
    logic [CNT_W-1:0] wr_count_r;

    // Grant selection: reset and HOLD suppress all grants, contention resolved by pri_r
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (RESET || HOLD) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (P0_VALID && P1_VALID) begin
            if (pri_r) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (P0_VALID) begin
            grant0_s = 1'b1;
        end else if (P1_VALID) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Mux the granted request; a transfer to x0 is accepted but never committed
    always_comb begin
        sel_addr_s = P0_ADDR;
        sel_data_s = P0_DATA;
        if (grant1_s) begin
            sel_addr_s = P1_ADDR;
            sel_data_s = P1_DATA;
        end else begin
            sel_addr_s = P0_ADDR;
            sel_data_s = P0_DATA;
        end
        commit_s = (grant0_s || grant1_s) && (sel_addr_s != 5'd0);
    end

    // Write-port registers, commit counter and round-robin pointer
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a3_r        <= 5'd0;
            wd3_r       <= 32'd0;
            reg_write_r <= 1'b0;
            wr_count_r  <= '0;
            pri_r       <= FIRST_PORT;
        end else begin
            reg_write_r <= commit_s;
            if (commit_s) begin
                a3_r       <= sel_addr_s;
                wd3_r      <= sel_data_s;
                wr_count_r <= wr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (grant0_s) begin
                pri_r <= 1'b1;
            end else if (grant1_s) begin
                pri_r <= 1'b0;
            end
        end
    end

    assign P0_READY = grant0_s;
    assign P1_READY = grant1_s;
    assign A3       = a3_r;
    assign WD3      = wd3_r;
    assign RegWrite = reg_write_r;
    assign WR_COUNT = wr_count_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (CNT_W=4 so the counter wrap is reachable).
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        HOLD;
    logic        P0_VALID;
    logic [4:0]  P0_ADDR;
    logic [31:0] P0_DATA;
    logic        P0_READY;
    logic        P1_VALID;
    logic [4:0]  P1_ADDR;
    logic [31:0] P1_DATA;
    logic        P1_READY;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        RegWrite;
    logic [3:0]  WR_COUNT;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.CNT_W(4), .FIRST_PORT(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .HOLD(HOLD),
        .P0_VALID(P0_VALID), .P0_ADDR(P0_ADDR), .P0_DATA(P0_DATA), .P0_READY(P0_READY),
        .P1_VALID(P1_VALID), .P1_ADDR(P1_ADDR), .P1_DATA(P1_DATA), .P1_READY(P1_READY),
        .A3(A3), .WD3(WD3), .RegWrite(RegWrite), .WR_COUNT(WR_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic hold);
        P0_VALID = v0; P0_ADDR = a0; P0_DATA = d0;
        P1_VALID = v1; P1_ADDR = a1; P1_DATA = d1;
        HOLD = hold;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b1, 5'd3, 32'h5, 1'b1, 5'd4, 32'h6, 1'b0);
        #12;
        check_val("rst_p0_ready", P0_READY, 32'd0);
        check_val("rst_p1_ready", P1_READY, 32'd0);
        check_val("rst_regwrite", RegWrite, 32'd0);
        check_val("rst_a3",       A3,       32'd0);
        check_val("rst_wd3",      WD3,      32'd0);
        check_val("rst_count",    WR_COUNT, 32'd0);

        // single port, first edge after reset
        @(negedge CLK);
        RESET = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        #1;
        check_val("single_p0_ready", P0_READY, 32'd1);
        check_val("single_p1_ready", P1_READY, 32'd0);
        @(posedge CLK); #1;
        check_val("single_regwrite", RegWrite, 32'd1);
        check_val("single_a3",       A3,       32'd5);
        check_val("single_wd3",      WD3,      32'hDEADBEEF);
        check_val("single_count",    WR_COUNT, 32'd1);

        // contention after fresh reset: P0,P1,P0,P1
        do_reset();
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("cont_p0_ready", P0_READY, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_val("cont_p1_ready", P1_READY, (i % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge CLK); #1;
            check_val("cont_regwrite", RegWrite, 32'd1);
            check_val("cont_a3",  A3,  (i % 2 == 0) ? 32'd1 : 32'd2);
            check_val("cont_wd3", WD3, (i % 2 == 0) ? 32'h11 : 32'h22);
            check_val("cont_count", WR_COUNT, i + 1);
            @(negedge CLK);
        end

        // idle cycle: outputs hold, no write
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge CLK); #1;
        check_val("idle_regwrite", RegWrite, 32'd0);
        check_val("idle_a3",       A3,       32'd2);
        check_val("idle_wd3",      WD3,      32'h22);
        check_val("idle_count",    WR_COUNT, 32'd4);

        // x0 write accepted but dropped
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
        #1;
        check_val("x0_p1_ready", P1_READY, 32'd1);
        @(posedge CLK); #1;
        check_val("x0_regwrite", RegWrite, 32'd0);
        check_val("x0_a3",       A3,       32'd2);
        check_val("x0_wd3",      WD3,      32'h22);
        check_val("x0_count",    WR_COUNT, 32'd4);

        // HOLD for 3 cycles, then grant to pointer (P0 after the P1 grant)
        @(negedge CLK);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("hold_p0_ready", P0_READY, 32'd0);
            check_val("hold_p1_ready", P1_READY, 32'd0);
            @(posedge CLK); #1;
            check_val("hold_regwrite", RegWrite, 32'd0);
            @(negedge CLK);
        end
        HOLD = 1'b0;
        #1;
        check_val("unhold_p0_ready", P0_READY, 32'd1);
        check_val("unhold_p1_ready", P1_READY, 32'd0);
        @(posedge CLK); #1;
        check_val("unhold_a3",    A3,       32'd3);
        check_val("unhold_count", WR_COUNT, 32'd5);

        // same address twice: P1 first (pointer), then P0, no merging
        @(negedge CLK);
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0);
        @(posedge CLK); #1;
        check_val("same1_wd3",   WD3,      32'hB);
        check_val("same1_count", WR_COUNT, 32'd6);
        @(negedge CLK);
        @(posedge CLK); #1;
        check_val("same2_regwrite", RegWrite, 32'd1);
        check_val("same2_wd3",      WD3,      32'hA);
        check_val("same2_a3",       A3,       32'd7);
        check_val("same2_count",    WR_COUNT, 32'd7);

        // reset between a transfer and its write cycle end
        @(negedge CLK);
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge CLK); #1;
        check_val("mid_pre_regwrite", RegWrite, 32'd1);
        check_val("mid_pre_count",    WR_COUNT, 32'd8);
        #1;
        RESET = 1'b1;
        #1;
        check_val("mid_regwrite", RegWrite, 32'd0);
        check_val("mid_count",    WR_COUNT, 32'd0);
        check_val("mid_a3",       A3,       32'd0);
        check_val("mid_p0_ready", P0_READY, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge CLK); #1;
        check_val("mid_post_regwrite", RegWrite, 32'd0);

        // 17 writes on a 4-bit counter: F, 0, 1
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            drive(1'b1, 5'((k % 31) + 1), 32'(k), 1'b0, 5'd0, 32'd0, 1'b0);
            @(posedge CLK); #1;
            if (k == 15) check_val("wrap_15", WR_COUNT, 32'hF);
            if (k == 16) check_val("wrap_16", WR_COUNT, 32'h0);
            if (k == 17) check_val("wrap_17", WR_COUNT, 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
